// File: rtl/adder_share_arbiter.sv
// Two-requester round-robin arbiter feeding one shared 52+29 bit adder and a result register.
// Latency: one cycle from accept (reqN_valid && reqN_ready) to out_valid.
// Backpressure: while out_valid && !out_ready nothing is granted and the result is held.
module adder_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [51:0]      req0_a,
  input  logic [28:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [51:0]      req1_a,
  input  logic [28:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [52:0]      out_sum,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      grant_cnt
);

  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             any_grant;
  logic             last_grant;
  logic [51:0]      op_a;
  logic [28:0]      op_b;
  logic [TAG_W-1:0] op_tag;
  logic [52:0]      sum;

  // The result register can take a new value when it is empty or being drained.
  assign slot_free = !out_valid || out_ready;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && slot_free) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign any_grant  = grant0 || grant1;

  // Operand mux ahead of the single shared adder; b is zero-extended.
  always_comb begin
    op_a   = grant1 ? req1_a   : req0_a;
    op_b   = grant1 ? req1_b   : req0_b;
    op_tag = grant1 ? req1_tag : req0_tag;
  end

  assign sum = {1'b0, op_a} + {24'b0, op_b};

  // Result register, round-robin history and saturating grant counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_src    <= 1'b0;
      out_tag    <= '0;
      grant_cnt  <= '0;
      last_grant <= 1'b1;
    end else if (any_grant) begin
      out_valid  <= 1'b1;
      out_sum    <= sum;
      out_src    <= grant1;
      out_tag    <= op_tag;
      last_grant <= grant1;
      if (grant_cnt != 16'hFFFF) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed and randomized checks of adder_share_arbiter against a behavioural model.
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [51:0] req0_a = '0, req1_a = '0;
  logic [28:0] req0_b = '0, req1_b = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [52:0] out_sum;
  logic        out_src;
  logic [3:0]  out_tag;
  logic [15:0] grant_cnt;

  adder_share_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_src(out_src),
    .out_tag(out_tag), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the result register should hold.
  logic        m_vld;
  logic [52:0] m_sum;
  int          m_src;
  logic [3:0]  m_tag;
  int          m_cnt;
  int          m_last;   // requester served most recently
  int          last_win; // requester granted in the last cycle, -1 for none

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_sum = '0; m_src = 0; m_tag = '0; m_cnt = 0; m_last = 1; last_win = -1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
    check({tag, ".out_sum"},   64'(out_sum),   64'(m_sum));
    check({tag, ".out_src"},   64'(out_src),   64'(m_src));
    check({tag, ".out_tag"},   64'(out_tag),   64'(m_tag));
    check({tag, ".grant_cnt"}, 64'(grant_cnt), 64'(m_cnt));
  endtask

  // One clock: predict the grant, check readys before the edge, then check the new result.
  task automatic cycle(input string tag);
    int   win;
    logic rdy;
    @(negedge clk);
    rdy = out_ready;
    win = -1;
    if (!reset && (!m_vld || rdy)) begin
      if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    check({tag, ".req0_ready"}, 64'(req0_ready), 64'(win == 0));
    check({tag, ".req1_ready"}, 64'(req1_ready), 64'(win == 1));
    @(posedge clk);
    #1;
    if (win == 0) begin
      m_vld = 1'b1; m_sum = {1'b0, req0_a} + {24'b0, req0_b}; m_src = 0; m_tag = req0_tag;
    end else if (win == 1) begin
      m_vld = 1'b1; m_sum = {1'b0, req1_a} + {24'b0, req1_b}; m_src = 1; m_tag = req1_tag;
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    if (win >= 0) begin
      m_last = win;
      if (m_cnt < 65535) m_cnt++;
    end
    last_win = win;
    check_outputs(tag);
  endtask

  // Assert reset away from the clock edge, check its immediate effect, release with requesters idle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".req0_ready"}, 64'(req0_ready), 64'd0);
    check({tag, ".req1_ready"}, 64'(req1_ready), 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    logic [31:0] r0, r1, r2, r3, r4, r5;
    r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
    r3 = $urandom(); r4 = $urandom(); r5 = $urandom();
    req0_a = {r0[19:0], r1}; req0_b = r2[28:0]; req0_tag = r2[31:28];
    req1_a = {r3[19:0], r4}; req1_b = r5[28:0]; req1_tag = r5[31:28];
  endtask

  logic [52:0] hold_sum;
  logic        hold_src;
  logic [3:0]  hold_tag;
  int          first_win;
  int          exp_rr[4] = '{0, 1, 0, 1};
  logic [31:0] rv;

  initial begin
    model_reset();
    req0_valid = 1'b1;  // must be masked while reset is high
    do_reset("reset");

    // Single request on requester 0.
    req0_valid = 1'b1; req0_a = 52'h1; req0_b = 29'h2; req0_tag = 4'd3; out_ready = 1'b1;
    cycle("single");
    check("single.sum_const", 64'(out_sum), 64'd3);
    req0_valid = 1'b0;
    cycle("single_drain");
    check("single_drain.valid", 64'(out_valid), 64'd0);

    // Contention straight after reset: strict alternation starting with requester 0.
    do_reset("rr_reset");
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      cycle("rr");
      check("rr.grant_order", 64'(last_win), 64'(exp_rr[i]));
    end
    check("rr.grant_cnt4", 64'(grant_cnt), 64'd4);

    // Backpressure: one result accepted, then everything frozen for 5 cycles.
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle("bp_idle");
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b0;
    rand_ops();
    cycle("bp_accept");
    first_win = last_win;
    hold_sum = out_sum; hold_src = out_src; hold_tag = out_tag;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      cycle("bp_hold");
      check("bp_hold.sum_stable", 64'(out_sum), 64'(hold_sum));
      check("bp_hold.src_stable", 64'(out_src), 64'(hold_src));
      check("bp_hold.tag_stable", 64'(out_tag), 64'(hold_tag));
      check("bp_hold.no_grant",   64'(last_win + 1), 64'd0);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_release.other_granted", 64'(last_win), 64'(1 - first_win));

    // Maximum operands produce a carry out.
    req1_valid = 1'b0;
    req0_a = 52'hF_FFFF_FFFF_FFFF; req0_b = 29'h1FFF_FFFF; req0_tag = 4'hA;
    cycle("carry");
    check("carry.sum_const", 64'(out_sum), 64'h10_0000_1FFF_FFFE);
    check("carry.bit52",     64'(out_sum[52]), 64'd1);

    // Reset while a result is held under backpressure.
    out_ready = 1'b0; req0_valid = 1'b1; rand_ops();
    cycle("midrst_load");
    cycle("midrst_hold");
    do_reset("midrst");
    cycle("midrst_after");
    check("midrst_after.valid", 64'(out_valid), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1; rand_ops();
    cycle("midrst_contend");
    check("midrst_contend.req0_wins", 64'(last_win), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rv = $urandom();
      req0_valid = rv[0]; req1_valid = rv[1]; out_ready = rv[2] | rv[3];
      rand_ops();
      cycle("rand");
    end

    // Counter saturation over 65540 back-to-back grants.
    do_reset("sat_reset");
    req0_valid = 1'b1; req1_valid = 1'b0; out_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat.cnt_fffe", 64'(grant_cnt), 64'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    check("sat.cnt_ffff", 64'(grant_cnt), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 SHALL have parameter: TAG_W, default 4, width of the per-request tag carried with each operation.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have port: req0_a  input  52  requester 0 wide operand.
REQ-007 SHALL have port: req0_b  input  29  requester 0 narrow operand.
REQ-008 SHALL have port: req0_tag  input  TAG_W  requester 0 tag.
REQ-009 SHALL have ports req1_valid, req1_ready, req1_a, req1_b, req1_tag, identical in direction, width and meaning to REQ-004..REQ-008, for requester 1.
REQ-010 SHALL have port: out_valid  output  1  result register holds a valid result.
REQ-011 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port: out_sum  output  53  registered sum, bit 52 = carry out.
REQ-013 SHALL have port: out_src  output  1  index of the requester that produced out_sum.
REQ-014 SHALL have port: out_tag  output  TAG_W  tag of the granted request.
REQ-015 SHALL have port: grant_cnt  output  16  saturating count of accepted operations since reset.

Function
REQ-016 SHALL instantiate exactly one shared adder computing a + zero-extended b (b padded with 23 leading zeros to 52 bits), producing a 53-bit unsigned result; no other adder on the operand path.
REQ-017 SHALL define slot_free = !out_valid || out_ready (combinational).
REQ-018 SHALL grant at most one requester per cycle; reqN_ready = grant to N; no grant when slot_free = 0.
REQ-019 SHALL grant the only valid requester when exactly one reqN_valid is high and slot_free = 1.
REQ-020 SHALL, when both are valid and slot_free = 1, grant the requester not granted last (round-robin via a 1-bit last_grant register).
REQ-021 SHALL update last_grant only on a grant; it is unchanged on idle cycles.
REQ-022 SHALL on a grant load out_sum, out_src and out_tag from the granted operands on the same edge and set out_valid = 1; latency is one cycle from accept to out_valid.
REQ-023 SHALL, on out_valid && out_ready with no grant, clear out_valid the next cycle; out_sum, out_src and out_tag keep their last values.
REQ-024 SHALL, on out_valid && out_ready with a grant in the same cycle, replace the result with no bubble, sustaining one operation per cycle.
REQ-025 SHALL hold out_sum, out_src, out_tag and out_valid stable while out_valid && !out_ready (backpressure); reqN_ready = 0 in that case.
REQ-026 SHALL make reqN_ready independent of out_sum and of the other requester's operands; reqN_ready depends only on the valid inputs, slot_free and last_grant.
REQ-027 SHALL increment grant_cnt by 1 per grant and saturate at 16'hFFFF.
REQ-028 SHALL produce a carry at the maximum operands: a = 52'hF_FFFF_FFFF_FFFF, b = 29'h1FFF_FFFF gives out_sum = 53'h10_0000_1FFF_FFFE.

Reset
REQ-029 SHALL, while reset is high, force out_valid = 0, out_sum = 0, out_src = 0, out_tag = 0, grant_cnt = 0 and last_grant = 1, so requester 0 wins the first contention.
REQ-030 SHALL, when reset is asserted mid-operation, discard any pending result; no result is delivered after reset deasserts.
REQ-031 SHALL drive req0_ready = req1_ready = 0 while reset is high.

Verification
REQ-032 SHALL cover single request: req0 a=52'h1, b=29'h2, tag=3, out_ready=1 -> next cycle out_valid=1, out_sum=3, out_src=0, out_tag=3.
REQ-033 SHALL cover contention: both requesters valid for 4 cycles after reset, out_ready=1 -> grants 0,1,0,1 and grant_cnt=4.
REQ-034 SHALL cover backpressure: out_ready=0 with both requesters valid -> one result accepted, then both readys stay 0 and the output stays stable for 5 cycles; out_ready=1 -> the other requester is granted in the same cycle.
REQ-035 SHALL cover carry: the REQ-028 operands -> out_sum[52]=1, out_sum = 53'h10_0000_1FFF_FFFE.
REQ-036 SHALL cover reset mid-operation: reset pulse while out_valid=1 and out_ready=0 -> out_valid=0 and grant_cnt=0 immediately, and requester 0 wins the first contention afterwards.
REQ-037 SHALL cover saturation: 65540 consecutive grants -> grant_cnt=16'hFFFF.
